// File: rtl/fetch_block_pkg.sv
// Shared types and constants for the Thumb fetch stage.
package fetch_block_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned INSTR_W = 16;

  typedef logic [WORD_W-1:0]  word;
  typedef logic [INSTR_W-1:0] instruction;
  typedef logic               stall_pipeline_sig;
  typedef logic               flush_pipeline_sig;

  // Bytes per 16-bit Thumb instruction.
  localparam word PC_INCREMENT = WORD_W'(2);

  typedef enum logic {
    RUN,
    STALLED
  } fetch_state_e;

  // Instruction together with the address it was fetched from.
  typedef struct packed {
    instruction instr;
    word        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_block_decode_register.sv
// Fetch/decode pipeline register: instruction, PC and valid with load/hold/invalidate.
module fetch_decode_register
  import fetch_block_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         invalidate,
  input  fetch_entry_t next_entry,
  input  logic         next_valid,
  output instruction   instr,
  output word          pc,
  output logic         valid
);

  // Reset clears everything; invalidate only drops valid; otherwise load or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_entry.instr;
      pc    <= next_entry.pc;
      valid <= next_valid;
    end
  end

endmodule

// File: rtl/fetch_block.sv
// Instruction fetch stage: PC, synchronous imem issue, one-entry skid buffer, flush redirect.
module fetch_block
  import fetch_block_pkg::*;
#(
  parameter word RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  stall_pipeline_sig stall_pipeline_i,
  input  flush_pipeline_sig flush_pipeline_i,
  input  word               branch_target_i,
  input  instruction        imem_data_i,
  output word               imem_addr_o,
  output logic              imem_en_o,
  output instruction        instruction_o,
  output word               program_counter_o,
  output logic              is_valid_o
);

  fetch_state_e state_q, state_d;
  word          pc_q, pc_d;
  logic         inflight_valid_q, inflight_valid_d;
  word          inflight_pc_q, inflight_pc_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t skid_q, skid_d;
  logic         out_load;
  fetch_entry_t out_entry;
  logic         out_valid;

  assign imem_addr_o = pc_q;
  // A read is issued on every edge that advances the PC, including the edge leaving STALLED,
  // so the instruction recorded as inflight is always the one the memory actually returns.
  assign imem_en_o = !reset_i && !flush_pipeline_i && !stall_pipeline_i;

  // State, PC, inflight and skid registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= RUN;
      pc_q             <= RESET_VECTOR;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      skid_valid_q     <= 1'b0;
      skid_q           <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      skid_valid_q     <= skid_valid_d;
      skid_q           <= skid_d;
    end
  end

  // Next-state logic: flush beats stall; stall parks the inflight read in the skid buffer.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    skid_valid_d     = skid_valid_q;
    skid_d           = skid_q;
    out_load         = 1'b0;
    out_entry        = '{instr: imem_data_i, pc: inflight_pc_q};
    out_valid        = inflight_valid_q;

    if (flush_pipeline_i) begin
      pc_d             = branch_target_i & ~WORD_W'(1);
      inflight_valid_d = 1'b0;
      skid_valid_d     = 1'b0;
      state_d          = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_pipeline_i) begin
            if (inflight_valid_q) begin
              skid_d       = '{instr: imem_data_i, pc: inflight_pc_q};
              skid_valid_d = 1'b1;
            end
            inflight_valid_d = 1'b0;
            state_d          = STALLED;
          end else begin
            out_load         = 1'b1;
            inflight_pc_d    = pc_q;
            inflight_valid_d = 1'b1;
            pc_d             = pc_q + PC_INCREMENT;
          end
        end
        STALLED: begin
          if (!stall_pipeline_i) begin
            out_load         = 1'b1;
            out_entry        = skid_q;
            out_valid        = skid_valid_q;
            skid_valid_d     = 1'b0;
            inflight_pc_d    = pc_q;
            inflight_valid_d = 1'b1;
            pc_d             = pc_q + PC_INCREMENT;
            state_d          = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  fetch_decode_register u_fd_reg (
    .clk        (clk_i),
    .reset      (reset_i),
    .load       (out_load),
    .invalidate (flush_pipeline_i),
    .next_entry (out_entry),
    .next_valid (out_valid),
    .instr      (instruction_o),
    .pc         (program_counter_o),
    .valid      (is_valid_o)
  );

endmodule
